instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction-fetch front end for the pipelined MIPS core.
//  Owns the fetch PC, issues requests to instruction memory over a valid/ready link, and buffers returned words with their PC.
//  Presents one instruction per cycle to the IF/ID boundary, honouring the hazard unit's stall.
//  Supports a branch/jump redirect that flushes buffered and in-flight fetches.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset
//  DEPTH     4              buffer entries; also max (buffered + outstanding); power of 2, >=2
// PORTS
//  clk             in   1   single clock, rising edge
//  reset           in   1   synchronous, active-high
//  stall_i         in   1   decode not accepting (StallF/StallD); holds output
//  redirect_i      in   1   taken branch/jump resolved this cycle
//  redirect_pc_i   in   32  new fetch target; bits[1:0] ignored (forced 0)
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  word-aligned fetch address
//  imem_resp_valid in   1   in-order response; cannot be back-pressured
//  imem_resp_data  in   32  instruction word
//  instr_valid     out  1   buffer head valid
//  instr           out  32  head instruction
//  instr_pc        out  32  PC of head instruction
//  instr_pc_plus4  out  32  instr_pc + 4, mod 2^32
// BEHAVIOUR
//  Reset:
//   - fetch_pc = resp_pc = RESET_PC.
//   - outstanding = drop_cnt = 0; buffer empty.
//   - imem_req_valid = 0 and instr_valid = 0 in the cycle after reset.
//   - instr, instr_pc and instr_pc_plus4 = 0 while instr_valid = 0.
//   - Memory shares this reset; no pre-reset response arrives afterwards.
//  Request:
//   - imem_req_valid = !redirect_i && (count + outstanding < DEPTH); imem_req_addr = fetch_pc.
//   - On valid&&ready: fetch_pc += 4 (wraps at 2^32); outstanding++.
//   - valid is not held once raised: it is a pure function of the credit check, so it may drop without ready.
//  Response:
//   - Each resp_valid decrements outstanding.
//   - If drop_cnt > 0: word is discarded; drop_cnt--.
//   - Else: push {resp_pc, data}; resp_pc += 4.
//   - Credit rule guarantees the push never hits a full buffer.
//   - resp_valid with outstanding == 0 is a protocol error: ignored, assertion fires.
//  Output:
//   - Head is register-sourced; no bypass.
//   - Response at cycle N appears on instr at N+1 at the earliest.
//   - Pop when instr_valid && !stall_i.
//   - Push and pop in the same cycle keep count unchanged; full throughput is 1 instr/cycle.
//  Redirect (highest priority, beats stall and pop):
//   - Next cycle: buffer empty; fetch_pc = resp_pc = {redirect_pc_i[31:2], 2'b00}.
//   - drop_cnt = outstanding - resp_valid (same-cycle response discarded); no request issued that cycle.
//   - Back-to-back redirects: each reloads the PCs; drop_cnt is recomputed from live outstanding.
//  Counters:
//   - outstanding and drop_cnt are $clog2(DEPTH)+1 bits wide.
//   - Simultaneous accept and response leave outstanding unchanged.
//  Mid-operation reset: state is cleared exactly as at power-up, regardless of stall or redirect.
// STRUCTURE
//  Shared pkg/defines:
//   - RESET_PC default, INSTR_W = 32, PC_INC = 4.
//  Sub-module fetch_fifo:
//   - Sync FIFO, DEPTH x 64 bits {pc, instr}.
//   - Ports: push, pop, flush, count, head; flush has priority over push and pop.
//  Top level: fetch_pc/resp_pc registers, outstanding/drop counters, request credit logic.
// TESTING
//  1. Reset, ready = 1, 1-cycle memory latency -> addrs 0,4,8,... on consecutive cycles.
//     instr_valid first at cycle 3; instr_pc = 0, 4, 8 with no bubbles.
//  2. stall_i held 6 cycles, ready = 1 -> count + outstanding reaches 4 and req_valid drops.
//     Head stays PC 0 throughout; release -> PCs 0, 4, 8, 12 drain in order.
//  3. 3 outstanding at 3-cycle latency, redirect_i with pc 0x40 -> next cycle instr_valid = 0.
//     The 3 stale responses are dropped; first instr_pc = 0x40, then 0x44.
//  4. redirect_pc_i = 0x103 -> imem_req_addr = 0x100.
//     Redirect coinciding with stall_i = 1 and resp_valid = 1 -> that response dropped, buffer flushed.
//  5. fetch_pc = 0xFFFF_FFFC -> next addr 0x0000_0000.
//     instr_pc_plus4 for 0xFFFF_FFFC = 0x0.
//  6. reset asserted mid-stream with 2 buffered and 2 outstanding -> next cycle all outputs 0.
//     Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   INSTR_W          : instruction and PC width
//   DEFAULT_RESET_PC : default first fetch address after reset
//   PC_INC           : distance between consecutive instruction words
//   fetch_entry_t    : one buffered fetch result, {pc, instr}
//   word_align()     : clears the byte-offset bits of an address
package instr_fetch_unit_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
        return {addr[INSTR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   push       : write push_data at the tail (caller guarantees not full)
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the FIFO; wins over push and pop
//   count      : number of valid entries, 0..DEPTH
//   head       : oldest entry, read straight from storage (no write bypass)
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: nothing is read until count says so.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, requests words from
// instruction memory, buffers returned words with their PC and presents one
// instruction per cycle to decode. A redirect flushes buffered and in-flight
// fetches.
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   stall_i          : decode not accepting; head is held
//   redirect_i       : taken branch/jump; redirect_pc_i is the new target
//   imem_req_*       : request channel (valid/ready), word-aligned address
//   imem_resp_*      : in-order response, no back-pressure
//   instr_valid      : head of buffer valid
//   instr, instr_pc, instr_pc_plus4 : head contents, zero when not valid
//
// Handshake: a request transfers on a rising edge where imem_req_valid and
// imem_req_ready are both high. imem_req_valid is a pure function of the
// credit check and may drop without ready having been seen. Responses have
// no ready: every imem_resp_valid cycle delivers exactly one word.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [INSTR_W-1:0] redirect_pc_i,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [INSTR_W-1:0] imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] instr_pc,
    output logic [INSTR_W-1:0] instr_pc_plus4
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [INSTR_W-1:0] fetch_pc;
    logic [INSTR_W-1:0] resp_pc;
    logic [INSTR_W-1:0] redirect_target;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      drop_cnt;
    logic [CW-1:0]      count;
    logic [CW:0]        credit_used;
    logic               started;
    logic               req_fire;
    logic               resp_ok;
    logic               push;
    logic               pop;
    fetch_entry_t       push_data;
    fetch_entry_t       head;

    assign redirect_target = word_align(redirect_pc_i);

    // Buffered plus in-flight words may never exceed DEPTH, so every response
    // is guaranteed a free slot. started keeps requests off for the first
    // cycle after reset.
    assign credit_used    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = started && !redirect_i && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_ok   = imem_resp_valid && (outstanding != '0);
    assign push      = resp_ok && (drop_cnt == '0);
    assign push_data = '{pc: resp_pc, instr: imem_resp_data};
    assign pop       = instr_valid && !stall_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            started     <= 1'b0;
        end else begin
            started     <= 1'b1;
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_ok);
            if (redirect_i) begin
                // Everything still in flight is stale; a response arriving
                // this very cycle is already discarded, so it is not counted.
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                drop_cnt <= outstanding - CW'(resp_ok);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_INC;
                end
                if (push) begin
                    resp_pc <= resp_pc + PC_INC;
                end
                if (resp_ok && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
        end
    end

    // Redirect drives flush, which beats any same-cycle push or pop.
    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_i),
        .count     (count),
        .head      (head)
    );

    assign instr_valid    = (count != '0);
    assign instr          = instr_valid ? head.instr : '0;
    assign instr_pc       = instr_valid ? head.pc : '0;
    assign instr_pc_plus4 = instr_valid ? (head.pc + PC_INC) : '0;

    resp_without_request: assert property (
        @(posedge clk) disable iff (reset) !(imem_resp_valid && (outstanding == '0))
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat     = 1;

    // Scoreboard: {pc, instr} expected at the head, in order.
    logic [63:0] exp_q[$];
    logic [31:0] exp_fetch;
    logic        wrap_seen;

    // Memory model: accepted addresses and the cycle their word is returned.
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_pc_plus4  (instr_pc_plus4)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] x;
        x = a ^ 32'h5A5A_1234;
        return x * 32'h9E37_79B1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Scoreboard update for the current cycle, called away from the clock edge.
    task automatic sample();
        logic [63:0] e;
        if (reset) begin
            exp_q.delete();
            mem_addr_q.delete();
            mem_due_q.delete();
            exp_fetch = 32'h0000_0000;
            return;
        end
        if (instr_valid && !stall_i && !redirect_i) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL pop_expected: observed pc %h expected no instruction", instr_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("instr_pc", instr_pc, e[63:32]);
                check("instr", instr, e[31:0]);
                check("instr_pc_plus4", instr_pc_plus4, e[63:32] + 32'd4);
                if (e[63:32] == 32'hFFFF_FFFC) wrap_seen = 1'b1;
            end
        end
        if (redirect_i) begin
            check_bit("req_valid_on_redirect", imem_req_valid, 1'b0);
            exp_q.delete();
            exp_fetch = {redirect_pc_i[31:2], 2'b00};
        end else if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_fetch);
            exp_q.push_back({exp_fetch, mem_word(exp_fetch)});
            mem_addr_q.push_back(imem_req_addr);
            mem_due_q.push_back(cyc + lat);
            exp_fetch = exp_fetch + 32'd4;
        end
    endtask

    // One clock cycle: score at the falling edge, then drive the response.
    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
        if (mem_due_q.size() != 0 && mem_due_q[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_addr_q.pop_front());
            mem_due_q.delete(0);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        redirect_i = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_bit({tag, "_req_valid"}, imem_req_valid, 1'b0);
        check_bit({tag, "_instr_valid"}, instr_valid, 1'b0);
        check({tag, "_instr"}, instr, 32'h0);
        check({tag, "_instr_pc"}, instr_pc, 32'h0);
        check({tag, "_instr_pc_plus4"}, instr_pc_plus4, 32'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int first_valid;
        logic found;

        reset           = 1'b1;
        stall_i         = 1'b0;
        redirect_i      = 1'b0;
        redirect_pc_i   = 32'h0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        exp_fetch       = 32'h0;
        wrap_seen       = 1'b0;

        // 1. reset state, then streaming at 1-cycle latency
        lat = 1;
        do_reset();
        first_valid = -1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i == 0) check_outputs_zero("rst");
            else if (i <= 4) check_bit("t1_req_valid", imem_req_valid, 1'b1);
            if (instr_valid && first_valid < 0) first_valid = i;
            if (i >= 3) check_bit("t1_no_bubble", instr_valid, 1'b1);
            step();
        end
        check("t1_first_valid", first_valid, 3);

        // 2. stall fills the credit window, head holds, then drains in order
        stall_i = 1'b1;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            #1;
            if (i >= 3) begin
                check_bit("t2_head_valid", instr_valid, 1'b1);
                check("t2_head_pc", instr_pc, 32'h0);
            end
            if (i >= 5) check_bit("t2_credit_stop", imem_req_valid, 1'b0);
            step();
        end
        stall_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (i < 4) check("t2_drain_pc", instr_pc, 32'(4 * i));
            step();
        end

        // 3. redirect with 3 outstanding at 3-cycle latency
        lat = 3;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            redirect_i    = (i == 4);
            redirect_pc_i = 32'h0000_0040;
            #1;
            if (i >= 5 && i <= 8) check_bit("t3_stale_dropped", instr_valid, 1'b0);
            if (i == 9) check("t3_first_pc", instr_pc, 32'h0000_0040);
            if (i == 10) check("t3_second_pc", instr_pc, 32'h0000_0044);
            step();
        end
        redirect_i = 1'b0;

        // 4. misaligned redirect together with stall and a live response
        stall_i = 1'b1;
        found   = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            #1;
            if (imem_resp_valid && instr_valid) found = 1'b1;
            else step();
        end
        check_bit("t4_setup", found, 1'b1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        #1;
        step();
        redirect_i = 1'b0;
        stall_i    = 1'b0;
        #1;
        check_bit("t4_flushed", instr_valid, 1'b0);
        check_bit("t4_req_valid", imem_req_valid, 1'b1);
        check("t4_req_addr", imem_req_addr, 32'h0000_0100);
        for (int i = 0; i < 8; i++) step();

        // 5. PC wrap at 2^32
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        #1;
        step();
        redirect_i = 1'b0;
        for (int i = 0; i < 14; i++) begin
            #1;
            if (instr_valid && instr_pc == 32'hFFFF_FFFC)
                check("t5_plus4_wrap", instr_pc_plus4, 32'h0);
            step();
        end
        check_bit("t5_wrap_seen", wrap_seen, 1'b1);

        // random ready / stall / redirect traffic
        for (int i = 0; i < 40; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            stall_i        = ($urandom_range(0, 3) == 0);
            redirect_i     = ($urandom_range(0, 11) == 0);
            redirect_pc_i  = $urandom;
            step();
        end
        imem_req_ready = 1'b1;
        stall_i        = 1'b0;
        redirect_i     = 1'b0;
        for (int i = 0; i < 12; i++) step();

        // 6. reset mid-stream with 2 buffered and 2 outstanding
        lat     = 3;
        stall_i = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) step();
        reset = 1'b1;
        step();
        reset   = 1'b0;
        stall_i = 1'b0;
        lat     = 1;
        #1;
        check_outputs_zero("t6");
        step();
        #1;
        check_bit("t6_restart_valid", imem_req_valid, 1'b1);
        check("t6_restart_addr", imem_req_addr, 32'h0000_0000);
        for (int i = 0; i < 10; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
